uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx.sv | 126 ++++++++++++
 tb/tb_uart_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int DATA_BITS = 8;

    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_FULL  = 1;
    localparam int STATUS_EMPTY = 2;
    localparam int STATUS_OVF   = 3;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous transmit FIFO, power-of-two depth
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still legal.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - memory-mapped 8N1 UART transmitter with status word
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        io_wr,
    input  logic [7:0]  io_wdata,
    input  logic        io_rd,
    output logic [31:0] io_rdata,
    output logic        txd
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    tx_state_t                   state;
    logic [CW-1:0]               baud;
    logic [BW-1:0]               bit_idx;
    logic [DATA_BITS-1:0]        shift;
    logic                        overflow;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [DATA_BITS-1:0]        fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        baud_wrap;
    logic                        pop;
    logic                        busy;

    assign baud_wrap = (baud == BAUD_LAST);
    assign pop  = !fifo_empty && ((state == IDLE) || (state == STOP && baud_wrap));
    assign busy = (state != IDLE) || (fifo_count != '0);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (io_wr),
        .pop    (pop),
        .din    (io_wdata),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        io_rdata               = '0;
        io_rdata[STATUS_BUSY]  = busy;
        io_rdata[STATUS_FULL]  = fifo_full;
        io_rdata[STATUS_EMPTY] = fifo_empty;
        io_rdata[STATUS_OVF]   = overflow;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            overflow <= 1'b0;
        end else begin
            // A dropped write in the same cycle as a status read keeps the flag set.
            if (io_wr && fifo_full && !pop)
                overflow <= 1'b1;
            else if (io_rd)
                overflow <= 1'b0;

            if (state == IDLE)
                baud <= '0;
            else
                baud <= baud_wrap ? '0 : baud + 1'b1;

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift <= fifo_dout;
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        txd     <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_idx == BIT_LAST) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            txd     <= shift[1];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Chain straight into the next start bit when more data is queued.
                    if (baud_wrap) begin
                        if (!fifo_empty) begin
                            shift <= fifo_dout;
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b0;
    logic        io_wr    = 1'b0;
    logic [7:0]  io_wdata = 8'h00;
    logic        io_rd    = 1'b0;
    logic [31:0] io_rdata;
    logic        txd;

    int checks      = 0;
    int errors      = 0;
    int cycle       = 0;
    int frames_done = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .io_wr    (io_wr),
        .io_wdata (io_wdata),
        .io_rd    (io_rd),
        .io_rdata (io_rdata),
        .txd      (txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FRAME-1:0] frame_vec(input logic [7:0] b);
        logic [FRAME-1:0] v;
        for (int i = 0; i < FRAME; i++) begin
            if (i < CPB)          v[i] = 1'b0;
            else if (i < 9 * CPB) v[i] = b[(i - CPB) / CPB];
            else                  v[i] = 1'b1;
        end
        return v;
    endfunction

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [7:0] b, input bit accept);
        io_wr    = 1'b1;
        io_wdata = b;
        if (accept) exp_q.push_back(b);
        @(negedge clk);
        io_wr = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cycle < target) @(negedge clk);
    endtask

    task automatic get_start(output int s);
        if (start_q.size() == 0) s = -1;
        else s = start_q.pop_front();
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || io_rdata[0]) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check(name, 64'(g < 3000), 64'd1);
    endtask

    // Monitor: captures every txd frame cycle by cycle and compares against the queue head.
    initial begin : monitor
        logic             prev;
        logic [FRAME-1:0] samp;
        bit               aborted;
        logic [7:0]       e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (resetn && prev && !txd) begin
                start_q.push_back(cycle);
                samp    = '0;
                samp[0] = txd;
                aborted = 1'b0;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge clk);
                    if (!resetn) begin
                        aborted = 1'b1;
                        break;
                    end
                    samp[i] = txd;
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %h expected none", samp);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame", 64'(samp), 64'(frame_vec(e)));
                        frames_done++;
                    end
                end
            end
            prev = resetn ? txd : 1'b1;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int n, s0, s1, cnt, fd;

        repeat (3) @(negedge clk);
        check("reset_txd", 64'(txd), 64'd1);
        check("reset_status", 64'(io_rdata), 64'h4);
        resetn = 1'b1;
        @(negedge clk);

        // Single frame 0xA5 from idle
        start_q.delete();
        n = cycle + 1;
        wr(8'hA5, 1'b1);
        cnt = 0;
        for (int i = 0; i <= 40; i++) begin
            if (io_rdata[0]) cnt++;
            if (i < 40) @(negedge clk);
        end
        check("t1_busy_frame", 64'(cnt), 64'd41);
        @(negedge clk);
        check("t1_busy_after", 64'(io_rdata[0]), 64'd0);
        get_start(s0);
        check("t1_start_cycle", 64'(s0), 64'(n + 1));

        // Two frames back-to-back
        start_q.delete();
        n = cycle + 1;
        wr(8'h01, 1'b1);
        wr(8'hFF, 1'b1);
        wait_until(n + 41);
        check("t2_status_after_pop2", 64'(io_rdata), 64'h5);
        wait_until(n + 81);
        check("t2_idle_status", 64'(io_rdata), 64'h4);
        get_start(s0);
        get_start(s1);
        check("t2_first_start", 64'(s0), 64'(n + 1));
        check("t2_gap", 64'(s1 - s0), 64'd40);

        // Six writes, last one dropped
        start_q.delete();
        n = cycle + 1;
        wr(8'h10, 1'b1);
        wr(8'h11, 1'b1);
        wr(8'h12, 1'b1);
        wr(8'h13, 1'b1);
        wr(8'h14, 1'b1);
        wr(8'h15, 1'b0);
        check("t3_status_full_ovf", 64'(io_rdata), 64'hB);

        // Overflow clearing, and set beating clear
        io_rd = 1'b1;
        @(negedge clk);
        io_rd = 1'b0;
        check("t4_ovf_cleared", 64'(io_rdata), 64'h3);
        io_rd = 1'b1;
        wr(8'h99, 1'b0);
        io_rd = 1'b0;
        check("t4_set_wins", 64'(io_rdata), 64'hB);
        io_rd = 1'b1;
        @(negedge clk);
        io_rd = 1'b0;
        check("t4_ovf_cleared2", 64'(io_rdata), 64'h3);

        // Push while full on the STOP-end pop of the 0x10 frame
        wait_until(n + 40);
        wr(8'h20, 1'b1);
        check("t6_full_no_ovf", 64'(io_rdata), 64'h3);
        wait_drain("t36_drain");
        check("t36_idle_status", 64'(io_rdata), 64'h4);
        get_start(s0);
        check("t3_first_start", 64'(s0), 64'(n + 1));

        // Reset in the middle of a frame
        start_q.delete();
        n = cycle + 1;
        wr(8'h55, 1'b0);
        wr(8'hAA, 1'b0);
        wr(8'hBB, 1'b0);
        wait_until(n + 15);
        check("t5_pre_status", 64'(io_rdata), 64'h1);
        resetn = 1'b0;
        #1;
        check("t5_txd_async", 64'(txd), 64'd1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("t5_post_status", 64'(io_rdata), 64'h4);
        fd = frames_done;
        repeat (150) @(negedge clk);
        check("t5_no_new_starts", 64'(start_q.size()), 64'd1);
        check("t5_no_new_frames", 64'(frames_done), 64'(fd));
        check("t5_txd_idle", 64'(txd), 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
